vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Consumes the 2-bit vend command produced by the coin-accumulation FSM and drives the physical dispense side of the vending machine: the motor, the drop sensor and the change/refund ejectors. It tracks item inventory, reports busy/sold-out/fault status back to the front panel, and sequences each vend as a timed, handshaked transaction.

## Interface
- MOTOR_CYCLES, default 8: motor_on pulse width in clk cycles (≥1).
- CHANGE_CYCLES, default 4: change_eject / refund pulse width in clk cycles (≥1).
- DROP_TIMEOUT, default 64: maximum cycles to wait for item_sensor after the motor stops.
- STOCK_W, default 4: inventory counter width.
- STOCK_INIT, default 15: value loaded on reset and on restock.
- Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd  in  2  vend command: 00 none, 10 dispense, 11 dispense plus change, 01 illegal.
- item_sensor  in  1  high while an item passes the drop chute (synchronous, level).
- restock  in  1  one-cycle pulse; reloads inventory.
- motor_on  out  1  dispense motor drive.
- change_eject  out  1  change coin ejector drive.
- refund  out  1  full-price refund ejector drive.
- busy  out  1  high in every state except IDLE.
- sold_out  out  1  high while stock == 0.
- vend_done  out  1  one-cycle pulse on successful vend completion.
- fault  out  1  drop-sensor timeout; sticky until rst.
- overrun  out  1  sticky: non-zero cmd arrived while busy; cleared by rst.
- stock  out  STOCK_W  current inventory.

## Operation
- States: IDLE, MOTOR, DROP_WAIT, CHANGE, REFUND, DONE, FAULT.
- IDLE: cmd 10/11 with stock != 0 → MOTOR; change flag latched = cmd[0]. cmd 10/11 with stock == 0 → REFUND. cmd 00/01 → stay, no flag.
- MOTOR: motor_on high for exactly MOTOR_CYCLES cycles → DROP_WAIT.
- DROP_WAIT: item_sensor high → stock decrements by 1; go to CHANGE if the change flag is set, else DONE. No sensor within DROP_TIMEOUT cycles → FAULT.
- CHANGE: change_eject high for CHANGE_CYCLES cycles → DONE.
- REFUND: refund high for CHANGE_CYCLES cycles → IDLE. No vend_done, stock unchanged.
- DONE: vend_done high for one cycle → IDLE.
- FAULT: motor_on, change_eject and refund all low; fault = 1, busy = 1. Exit only by rst.
- restock: honoured only in IDLE (stock ← STOCK_INIT); ignored in all other states. In IDLE, restock together with a vend cmd: the vend decision uses the pre-restock stock, and stock becomes STOCK_INIT.
- Non-zero cmd while busy: request dropped, overrun set. cmd 01 never sets overrun.
- Stock never underflows; decrement occurs only on the sensor hit, and a hit implies stock ≥ 1.

## Timing
- Reset values: state IDLE; stock = STOCK_INIT; all other outputs 0. sold_out reflects stock (0 at reset unless STOCK_INIT = 0).
- All outputs are registered, Moore-style, decoded from state and counter.
- cmd is sampled on edge N in IDLE; motor_on and busy are high from edge N+1 through edge N+MOTOR_CYCLES; DROP_WAIT is entered at edge N+MOTOR_CYCLES+1.
- item_sensor is sampled in DROP_WAIT; a hit on edge M updates stock at edge M+1, which is also the first cycle of CHANGE or DONE.
- A timeout fires on the DROP_TIMEOUT-th DROP_WAIT cycle without a hit; fault is high from the next edge.
- A new cmd is accepted on the first cycle after busy falls. cmd is a one-cycle pulse; it is edge-insensitive.
- rst mid-vend drops all drives in the same cycle (asynchronously) and restores stock to STOCK_INIT.

## Structure
- Package vend_pkg: cmd encodings (CMD_NONE, CMD_VEND, CMD_VEND_CHG) and the state enum. The upstream coin FSM shares the cmd encodings.
- Sub-module dispense_timer: a loadable down-counter with a done flag. It is instantiated once and reloaded per state with MOTOR_CYCLES, DROP_TIMEOUT or CHANGE_CYCLES.

## Test plan
- Reset, then cmd=10 for one cycle → motor_on high 8 cycles; item_sensor high 3 cycles later → stock 15→14, vend_done pulses once, change_eject never asserts.
- cmd=11, sensor hit → motor_on 8 cycles, then change_eject 4 cycles, then vend_done pulse; stock decrements by 1.
- Drain stock to 0 → sold_out = 1. Then cmd=10 → refund high 4 cycles, no motor_on, stock stays 0.
- cmd=10, item_sensor held low → fault rises 64 cycles after motor_on falls and stays high. busy stays 1. rst clears it.
- cmd=10 during MOTOR → overrun = 1 and no second vend. restock during DROP_WAIT is ignored. restock in IDLE → stock = 15.
- rst pulse in mid-CHANGE → change_eject falls immediately; state IDLE; stock = 15.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared vend command encodings and dispense-controller state
//                encoding. The upstream coin FSM uses the same cmd values.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Vend command encodings driven by the coin-accumulation FSM
    localparam logic [1:0] CMD_NONE     = 2'b00;
    localparam logic [1:0] CMD_ILLEGAL  = 2'b01;
    localparam logic [1:0] CMD_VEND     = 2'b10;
    localparam logic [1:0] CMD_VEND_CHG = 2'b11;

    // Dispense controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_DROP_WAIT = 3'd2,
        ST_CHANGE    = 3'd3,
        ST_REFUND    = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Both real vend commands have the MSB set; 01 is illegal and ignored
    function automatic logic is_vend_cmd(input logic [1:0] cmd);
        return cmd[1];
    endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/dispense_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dispense_timer
//  Description : Loadable down-counter. o_done is high while the count is
//                zero; loading N-1 makes the owning state last N cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispense_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule : dispense_timer
`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vend_dispense_ctrl
//  Description : Sequences motor / drop sensor / change / refund for each vend
//                command, tracks inventory and reports status.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES  = 8,
    parameter int CHANGE_CYCLES = 4,
    parameter int DROP_TIMEOUT  = 64,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_cmd,
    input  logic               i_item_sensor,
    input  logic               i_restock,
    output logic               o_motor_on,
    output logic               o_change_eject,
    output logic               o_refund,
    output logic               o_busy,
    output logic               o_sold_out,
    output logic               o_vend_done,
    output logic               o_fault,
    output logic               o_overrun,
    output logic [STOCK_W-1:0] o_stock
);

    // One shared timer must hold the longest of the three intervals
    localparam int c_TIMER_MAX = (MOTOR_CYCLES > DROP_TIMEOUT)
                               ? ((MOTOR_CYCLES > CHANGE_CYCLES) ? MOTOR_CYCLES : CHANGE_CYCLES)
                               : ((DROP_TIMEOUT > CHANGE_CYCLES) ? DROP_TIMEOUT : CHANGE_CYCLES);
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [STOCK_W-1:0]     r_stock;
    logic                   r_chg;
    logic                   r_overrun;
    logic                   w_tmr_done;
    logic                   w_tmr_load;
    logic [c_TIMER_W-1:0]   w_tmr_value;
    logic                   w_hit;

    // A sensor hit only counts while waiting for the drop
    assign w_hit = (r_state == ST_DROP_WAIT) && i_item_sensor && (r_stock != '0);

    // Reload the timer on every state change with the new state's duration
    assign w_tmr_load = (w_next != r_state);

    dispense_timer #(
        .WIDTH   (c_TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    // Duration (minus one) of the state being entered
    always_comb begin
        w_tmr_value = '0;
        case (w_next)
            ST_MOTOR:     w_tmr_value = c_TIMER_W'(MOTOR_CYCLES - 1);
            ST_DROP_WAIT: w_tmr_value = c_TIMER_W'(DROP_TIMEOUT - 1);
            ST_CHANGE,
            ST_REFUND:    w_tmr_value = c_TIMER_W'(CHANGE_CYCLES - 1);
            default:      w_tmr_value = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; FAULT is left only through reset
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (is_vend_cmd(i_cmd)) begin
                    w_next = (r_stock != '0) ? ST_MOTOR : ST_REFUND;
                end
            end
            ST_MOTOR: begin
                if (w_tmr_done) w_next = ST_DROP_WAIT;
            end
            ST_DROP_WAIT: begin
                if (w_hit) begin
                    w_next = r_chg ? ST_CHANGE : ST_DONE;
                end else if (w_tmr_done) begin
                    w_next = ST_FAULT;
                end
            end
            ST_CHANGE: begin
                if (w_tmr_done) w_next = ST_DONE;
            end
            ST_REFUND: begin
                if (w_tmr_done) w_next = ST_IDLE;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Inventory, change flag and sticky overrun bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stock   <= STOCK_W'(STOCK_INIT);
            r_chg     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                // Vend decision above uses the pre-restock stock value
                if (i_restock) r_stock <= STOCK_W'(STOCK_INIT);
                if (is_vend_cmd(i_cmd)) r_chg <= i_cmd[0];
            end else begin
                if (is_vend_cmd(i_cmd)) r_overrun <= 1'b1;
                if (w_hit) r_stock <= r_stock - STOCK_W'(1);
            end
        end
    end

    // Moore output decode from the state register
    always_comb begin
        o_motor_on     = (r_state == ST_MOTOR);
        o_change_eject = (r_state == ST_CHANGE);
        o_refund       = (r_state == ST_REFUND);
        o_vend_done    = (r_state == ST_DONE);
        o_fault        = (r_state == ST_FAULT);
        o_busy         = (r_state != ST_IDLE);
    end

    assign o_overrun  = r_overrun;
    assign o_stock    = r_stock;
    assign o_sold_out = (r_stock == '0);

endmodule : vend_dispense_ctrl
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_dispense_ctrl
//  Description : Self-checking bench for vend_dispense_ctrl with a
//                transaction-level reference model of inventory and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_ctrl;

    localparam int MC   = 8;
    localparam int CC   = 4;
    localparam int DT   = 64;
    localparam int SW   = 4;
    localparam int SINIT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic          item_sensor = 1'b0;
    logic          restock = 1'b0;
    logic          motor_on, change_eject, refund, busy, sold_out;
    logic          vend_done, fault, overrun;
    logic [SW-1:0] stock;

    int n_tests = 0;
    int n_fail  = 0;
    int m_stock = SINIT;
    bit m_ovr   = 1'b0;

    always #5 clk = ~clk;

    vend_dispense_ctrl #(
        .MOTOR_CYCLES  (MC),
        .CHANGE_CYCLES (CC),
        .DROP_TIMEOUT  (DT),
        .STOCK_W       (SW),
        .STOCK_INIT    (SINIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd          (cmd),
        .i_item_sensor  (item_sensor),
        .i_restock      (restock),
        .o_motor_on     (motor_on),
        .o_change_eject (change_eject),
        .o_refund       (refund),
        .o_busy         (busy),
        .o_sold_out     (sold_out),
        .o_vend_done    (vend_done),
        .o_fault        (fault),
        .o_overrun      (overrun),
        .o_stock        (stock)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_status(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stock"}, stock, m_stock);
        chk({tag, "_sold_out"}, sold_out, (m_stock == 0));
        chk({tag, "_overrun"}, overrun, m_ovr);
        chk({tag, "_fault"}, fault, 0);
    endtask

    // Asynchronous reset applied mid-cycle; all drives must drop at once
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_motor"}, motor_on, 0);
        chk({tag, "_change"}, change_eject, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stock"}, stock, SINIT);
        @(negedge clk);
        rst     = 1'b0;
        m_stock = SINIT;
        m_ovr   = 1'b0;
    endtask

    // One vend transaction issued at a negedge while idle.
    // hit_at: DROP_WAIT cycle (0-based) with the sensor hit, <0 for none.
    task automatic do_vend(input string tag, input logic [1:0] c, input int hit_at,
                           input bit rs_with, input logic [1:0] inj,
                           input bit rs_dw, input bit rst_chg);
        bit go;
        int n_busy = 0, n_motor = 0, n_chg = 0, n_ref = 0, n_done = 0;
        int done_cyc = -1, fault_cyc = -1, bad = 0;
        go      = (m_stock != 0);
        cmd     = c;
        restock = rs_with;
        @(negedge clk);
        cmd     = 2'b00;
        restock = 1'b0;
        if (rs_with) m_stock = SINIT;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            item_sensor = 1'b0;
            cmd         = 2'b00;
            restock     = 1'b0;
            if (fault) begin
                fault_cyc = cyc;
                break;
            end
            if (!busy) break;
            n_busy++;
            if (motor_on)     n_motor++;
            if (change_eject) n_chg++;
            if (refund)       n_ref++;
            if (vend_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (rst_chg && change_eject && n_chg == 2) begin
                apply_reset({tag, "_rst_chg"});
                return;
            end
            if (cyc == 2) cmd = inj;
            if (rs_dw && go && cyc == MC) restock = 1'b1;
            if (go && hit_at >= 0 && cyc == MC + hit_at) item_sensor = 1'b1;
            @(negedge clk);
        end
        m_ovr = m_ovr | inj[1];
        if (go && hit_at < 0) begin
            chk({tag, "_fault_time"}, fault_cyc, MC + DT);
            chk({tag, "_fault_motor"}, n_motor, MC);
            for (int k = 0; k < 10; k++) begin
                if (!fault || !busy || motor_on || change_eject || refund) bad++;
                @(negedge clk);
            end
            chk({tag, "_fault_sticky"}, bad, 0);
            chk({tag, "_fault_stock"}, stock, m_stock);
            apply_reset({tag, "_rst_fault"});
            check_idle_status({tag, "_after_rst"});
            return;
        end
        if (go) begin
            m_stock = m_stock - 1;
            chk({tag, "_motor"}, n_motor, MC);
            chk({tag, "_change"}, n_chg, c[0] ? CC : 0);
            chk({tag, "_refund"}, n_ref, 0);
            chk({tag, "_done"}, n_done, 1);
            chk({tag, "_done_last"}, done_cyc, n_busy - 1);
            chk({tag, "_busy_len"}, n_busy, MC + hit_at + 1 + (c[0] ? CC : 0) + 1);
        end else begin
            chk({tag, "_motor"}, n_motor, 0);
            chk({tag, "_refund"}, n_ref, CC);
            chk({tag, "_done"}, n_done, 0);
            chk({tag, "_busy_len"}, n_busy, CC);
        end
        check_idle_status(tag);
    endtask

    initial begin
        logic [1:0] rc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_status("reset");
        chk("reset_motor", motor_on, 0);
        chk("reset_done", vend_done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain vend, sensor three cycles after the motor stops
        do_vend("vend10", 2'b10, 3, 0, 2'b00, 0, 0);
        // Vend with change
        do_vend("vend11", 2'b11, $urandom_range(0, 10), 0, 2'b00, 0, 0);

        // Illegal command in IDLE does nothing
        cmd = 2'b01;
        @(negedge clk);
        cmd = 2'b00;
        chk("illegal_busy", busy, 0);
        check_idle_status("illegal");

        // Illegal command while busy must not set overrun
        do_vend("inj01", 2'b10, 1, 0, 2'b01, 0, 0);
        // Vend command during MOTOR sets overrun; restock in DROP_WAIT ignored
        do_vend("inj10", 2'b10, 2, 0, 2'b10, 1, 0);

        // Restock alone in IDLE
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        m_stock = SINIT;
        check_idle_status("restock_idle");

        // Drain inventory with random vends
        while (m_stock > 0) begin
            rc = 2'($urandom_range(2, 3));
            do_vend("drain", rc, $urandom_range(0, 20), 0, 2'b00, 0, 0);
        end
        chk("drained_sold_out", sold_out, 1);

        // Sold out: refund only
        do_vend("refund", 2'b10, 3, 0, 2'b00, 0, 0);
        // Sold out with restock in same cycle: refund decided on old stock
        do_vend("refund_rs", 2'b11, 3, 1, 2'b00, 0, 0);

        // Randomized mix
        for (int i = 0; i < 12; i++) begin
            rc = 2'($urandom_range(2, 3));
            do_vend("rand", rc, $urandom_range(0, DT - 1), ($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), 0);
        end

        // Restock together with a vend when stock is non-zero
        do_vend("vend_rs", 2'b10, 0, 1, 2'b00, 0, 0);

        // Drop sensor never fires: fault, then reset
        do_vend("timeout", 2'b10, -1, 0, 2'b00, 0, 0);

        // Reset in the middle of the change ejection
        do_vend("midchg", 2'b11, 2, 0, 2'b00, 0, 1);
        check_idle_status("midchg_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_vend_dispense_ctrl
`default_nettype wire
